touch_key_gen: RTL
==================

// Module: touch_key_gen
// PURPOSE
//   Generates clean touch_key tap waveforms (high press, low release) on command,
//   for driving key-input consumers such as the LED toggle block.
//   Each tap yields exactly one falling edge, so a consumer that toggles on that edge toggles once per tap.
//   Used for self-test and automated key sequences; sits between control logic and any touch_key input.
// PARAMETERS
//   PRESS_CYC  50_000  cycles touch_key is held high per tap (>=1)
//   GAP_CYC    50_000  cycles touch_key is held low after each tap (>=1)
//   CNT_W      16      width of the press/gap counter; must hold max(PRESS_CYC,GAP_CYC)
//   TAP_W      4       width of the tap-count request and status
// PORTS
//   sys_clk    in   1      system clock, all logic on rising edge
//   sys_rst_n  in   1      asynchronous active-low reset
//   start      in   1      request pulse; sampled only when busy=0
//   tap_num    in   TAP_W  number of taps to emit; latched with start
//   stop       in   1      synchronous abort; highest priority when busy=1
//   touch_key  out  1      generated key level, registered
//   busy       out  1      high while a sequence is in progress
//   done       out  1      one-cycle pulse when a sequence completes normally
//   tap_cnt    out  TAP_W  taps completed in the current/last sequence
// BEHAVIOUR
//   Reset (async): touch_key=0, busy=0, done=0, tap_cnt=0, counter=0, state=IDLE.
//   FSM states: IDLE -> PRESS -> GAP -> (PRESS | IDLE).
//   IDLE: on start=1 with tap_num!=0, latch tap_num, clear tap_cnt, go to PRESS.
//     start with tap_num==0 is ignored: no busy, no done, tap_cnt unchanged.
//   Timing: if start is accepted in cycle N, touch_key=1 and busy=1 from cycle N+1.
//   PRESS: touch_key=1 for exactly PRESS_CYC cycles, then go to GAP.
//   GAP: touch_key=0 for exactly GAP_CYC cycles.
//     tap_cnt increments on the first GAP cycle of each tap (same cycle as the falling edge).
//     At GAP end: if tap_cnt==latched tap_num, go to IDLE; otherwise go back to PRESS.
//   Completion: for T taps, done=1 and busy=0 in cycle N+T*(PRESS_CYC+GAP_CYC)+1.
//     done lasts exactly one cycle; tap_cnt holds its value until the next accepted start.
//   Back-to-back: start is accepted in the done cycle, since busy=0 there.
//     The new PRESS begins in the next cycle; the preceding GAP is still honoured in full.
//   start while busy=1: ignored; tap_num changes while busy have no effect.
//   stop while busy=1: next cycle state=IDLE, touch_key=0, busy=0, done=0.
//     tap_cnt keeps the taps completed so far.
//     Aborting in PRESS makes a falling edge; tap_cnt does not count this partial tap.
//   stop and start in the same IDLE cycle: stop wins, the request is dropped. stop in IDLE alone: no effect.
//   Mid-operation reset: all outputs return to reset values immediately; no done is issued.
//   tap_cnt increments are modulo 2^TAP_W, with no overflow for tap_num <= 2^TAP_W-1.
//   touch_key comes straight from a flop: glitch-free, with no combinational path from inputs.
// TESTING  (bench uses PRESS_CYC=4, GAP_CYC=3, TAP_W=4)
//   Reset, then start with tap_num=1 at cycle 10.
//     -> touch_key high in cycles 11-14 and low in 15-17; tap_cnt=1 at 15; done=1 and busy=0 at 18 only.
//   start with tap_num=3.
//     -> three 4-high/3-low pulses, 3 falling edges; done at start+22; tap_cnt=3.
//     -> A toggle-on-falling-edge LED model flips from 1 to 0, 1, 0.
//   start with tap_num=0 -> busy, done and touch_key stay 0 indefinitely.
//   start with tap_num=2, then start with tap_num=5 during busy.
//     -> only 2 taps are emitted.
//     -> A start asserted in the done cycle begins a new PRESS in the next cycle.
//   start with tap_num=4, stop at the 2nd cycle of the 3rd PRESS.
//     -> touch_key=0 and busy=0 next cycle; tap_cnt=2; no done.
//   Assert sys_rst_n=0 mid-PRESS, asynchronously between clock edges.
//     -> touch_key=0 and busy=0 immediately; after release, IDLE until the next start.

Source files
------------

// File: rtl/touch_key_gen.sv
// touch_key_gen: emits a commanded number of clean touch_key taps
// (PRESS_CYC cycles high, GAP_CYC cycles low), one falling edge per tap,
// with busy/done/tap_cnt status and a synchronous stop abort.
module touch_key_gen #(
    parameter int PRESS_CYC = 50_000,
    parameter int GAP_CYC   = 50_000,
    parameter int CNT_W     = 16,
    parameter int TAP_W     = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic [TAP_W-1:0] tap_num,
    input  logic             stop,
    output logic             touch_key,
    output logic             busy,
    output logic             done,
    output logic [TAP_W-1:0] tap_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(PRESS_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [TAP_W-1:0] tap_lat;

    // Tap sequencer: every output is a flop, so touch_key has no input-to-output path.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            tap_lat   <= '0;
            touch_key <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tap_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // stop in the same cycle drops the request; zero taps is no request
                    if (start && !stop && (tap_num != '0)) begin
                        tap_lat   <= tap_num;
                        tap_cnt   <= '0;
                        cnt       <= '0;
                        state     <= S_PRESS;
                        touch_key <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_PRESS: begin
                    if (stop) begin
                        state     <= S_IDLE;
                        cnt       <= '0;
                        touch_key <= 1'b0;
                        busy      <= 1'b0;
                    end else if (cnt == PRESS_LAST) begin
                        // falling edge and tap count land in the same cycle
                        cnt       <= '0;
                        state     <= S_GAP;
                        touch_key <= 1'b0;
                        tap_cnt   <= tap_cnt + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (stop) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        if (tap_cnt == tap_lat) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state     <= S_PRESS;
                            touch_key <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cnt       <= '0;
                    touch_key <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
